unidade_busca: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory word address.
- Captures the combinational instruction word into a fetch register and hands {instruction, PC} to the decoder with a valid/ready handshake.
- Applies branch/jump redirects, flushes the fetch register on redirect, and traps misaligned targets.

---
 rtl/pacote_riscv.sv | 11 +
 rtl/registrador_pc.sv | 22 ++
 rtl/unidade_busca.sv | 81 ++++++++
 tb/tb_unidade_busca.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pacote_riscv.sv
// Shared constants for the instruction-fetch slice: FSM encoding, PC step, NOP.
package pacote_riscv;

  localparam logic [1:0]  EST_INICIO = 2'd0;
  localparam logic [1:0]  EST_BUSCA  = 2'd1;
  localparam logic [1:0]  EST_ERRO   = 2'd2;

  localparam logic [31:0] INCR_PC    = 32'd4;
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0033;

endpackage

// File: rtl/registrador_pc.sv
// Program-counter register: redirect load has priority over sequential increment.
module registrador_pc
  import pacote_riscv::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        carrega,
  input  logic        incrementa,
  input  logic [31:0] alvo,
  output logic [31:0] pc
);

  // Load on redirect, step by one word on capture, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n)          pc <= RESET_PC;
    else if (carrega)    pc <= alvo;
    else if (incrementa) pc <= pc + INCR_PC;
  end

endmodule

// File: rtl/unidade_busca.sv
// Instruction-fetch stage: owns the PC, registers the memory word and hands
// {instruction, PC} to the decoder over valid/ready; traps misaligned redirects.
module unidade_busca
  import pacote_riscv::*;
#(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] endereco_instr,
  input  logic [31:0]       dado_instr,
  input  logic              desvio_valido,
  input  logic [31:0]       desvio_alvo,
  output logic [31:0]       instr_saida,
  output logic [31:0]       pc_saida,
  output logic              valido,
  input  logic              pronto,
  output logic              erro_alinhamento,
  output logic [31:0]       contador_instr
);

  logic [1:0]  estado;
  logic [31:0] pc;
  logic        em_busca, alinhado, desvio, captura, transfere;

  assign em_busca  = (estado == EST_BUSCA);
  assign alinhado  = (desvio_alvo[1:0] == 2'b00);
  assign desvio    = em_busca && desvio_valido;
  // A redirect in the same cycle drops the in-flight word, so it is not counted.
  assign captura   = em_busca && !desvio_valido && (!valido || pronto);
  assign transfere = valido && pronto && !desvio;

  // Memory sees only the word index; upper PC bits wrap silently.
  assign endereco_instr = pc[ADDR_W+1:2];

  registrador_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .carrega    (desvio && alinhado),
    .incrementa (captura),
    .alvo       (desvio_alvo),
    .pc         (pc)
  );

  // FSM, fetch register and trap flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado           <= EST_INICIO;
      instr_saida      <= '0;
      pc_saida         <= '0;
      valido           <= 1'b0;
      erro_alinhamento <= 1'b0;
    end else begin
      case (estado)
        EST_INICIO: estado <= EST_BUSCA;
        EST_BUSCA: begin
          if (desvio_valido) begin
            valido <= 1'b0;
            if (!alinhado) begin
              estado           <= EST_ERRO;
              erro_alinhamento <= 1'b1;
            end
          end else if (captura) begin
            instr_saida <= dado_instr;
            pc_saida    <= pc;
            valido      <= 1'b1;
          end
        end
        default: valido <= 1'b0;
      endcase
    end
  end

  // Count instructions actually accepted by the decoder.
  always_ff @(posedge clk) begin
    if (!rst_n)         contador_instr <= '0;
    else if (transfere) contador_instr <= contador_instr + 32'd1;
  end

endmodule

// File: tb/tb_unidade_busca.sv
// Self-checking bench for unidade_busca: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the fetch stage.
module tb_unidade_busca;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        desvio_valido = 1'b0;
  logic [31:0] desvio_alvo = '0;
  logic        pronto = 1'b1;

  logic [7:0]  endereco_instr, endereco2;
  logic [31:0] dado_instr, dado2;
  logic [31:0] instr_saida, pc_saida, contador_instr;
  logic [31:0] instr2, pcs2, cont2;
  logic        valido, erro_alinhamento, valido2, erro2;

  logic [31:0] mem [0:255];

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pcs, m_cnt;
  logic        m_v, m_err;
  int          m_fase; // 0 waiting one cycle after reset, 1 running, 2 trapped

  always #5 clk = ~clk;

  assign dado_instr = mem[endereco_instr];
  assign dado2      = mem[endereco2];

  unidade_busca #(.ADDR_W(8), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .endereco_instr(endereco_instr), .dado_instr(dado_instr),
    .desvio_valido(desvio_valido), .desvio_alvo(desvio_alvo),
    .instr_saida(instr_saida), .pc_saida(pc_saida), .valido(valido), .pronto(pronto),
    .erro_alinhamento(erro_alinhamento), .contador_instr(contador_instr)
  );

  unidade_busca #(.ADDR_W(8), .RESET_PC(32'h0000_03FC)) dut2 (
    .clk(clk), .rst_n(rst_n), .endereco_instr(endereco2), .dado_instr(dado2),
    .desvio_valido(desvio_valido), .desvio_alvo(desvio_alvo),
    .instr_saida(instr2), .pc_saida(pcs2), .valido(valido2), .pronto(pronto),
    .erro_alinhamento(erro2), .contador_instr(cont2)
  );

  // Advance one clock; the model applies the spec rules to the inputs seen at the edge.
  task automatic tick();
    if (!rst_n) begin
      m_pc = 32'h0; m_instr = 0; m_pcs = 0; m_cnt = 0; m_v = 0; m_err = 0; m_fase = 0;
    end else if (m_fase == 0) begin
      m_fase = 1;
    end else if (m_fase == 1) begin
      if (m_v && pronto && !desvio_valido) m_cnt = m_cnt + 1;
      if (desvio_valido) begin
        m_v = 0;
        if (desvio_alvo % 4 == 0) m_pc = desvio_alvo;
        else begin m_fase = 2; m_err = 1; end
      end else if (!m_v || pronto) begin
        m_instr = mem[(m_pc / 4) % 256];
        m_pcs = m_pc; m_v = 1; m_pc = m_pc + 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; desvio_valido = 0; pronto = 1;
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if (valido !== 1'b0 || instr_saida !== 32'h0 || pc_saida !== 32'h0) begin
      nerr++; $display("FAIL reset_out: valido=%b instr=%h pc=%h required 0/0/0", valido, instr_saida, pc_saida); end
    nvec++; if (erro_alinhamento !== 1'b0 || contador_instr !== 32'h0 || endereco_instr !== 8'd0) begin
      nerr++; $display("FAIL reset_misc: erro=%b cnt=%0d addr=%0d required 0/0/0", erro_alinhamento, contador_instr, endereco_instr); end
  endtask

  task automatic test_sequence();
    logic [31:0] exp_i [5];
    exp_i = '{32'h00002083, 32'h00102023, 32'h00108133, 32'h00110063, 32'h00000033};
    do_reset();
    tick();
    nvec++; if (valido !== 1'b0) begin nerr++; $display("FAIL inicio_valido: got %b required 0", valido); end
    for (int i = 0; i < 5; i++) begin
      tick();
      nvec++; if (valido !== 1'b1 || pc_saida !== 32'(4*i) || instr_saida !== exp_i[i]) begin
        nerr++; $display("FAIL seq_%0d: valido=%b pc=%h instr=%h required 1/%h/%h", i, valido, pc_saida, instr_saida, 32'(4*i), exp_i[i]); end
    end
    tick();
    nvec++; if (contador_instr !== 32'd5) begin nerr++; $display("FAIL seq_count: got %0d required 5", contador_instr); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick(); tick(); tick(); // INICIO, pc_saida 0, 4, 8
    pronto = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++; if (valido !== 1'b1 || pc_saida !== 32'd8 || instr_saida !== mem[2] || endereco_instr !== 8'd3 || contador_instr !== 32'd2) begin
        nerr++; $display("FAIL stall_%0d: v=%b pc=%h instr=%h addr=%0d cnt=%0d required 1/8/%h/3/2", i, valido, pc_saida, instr_saida, endereco_instr, contador_instr, mem[2]); end
    end
    pronto = 1;
    tick();
    nvec++; if (pc_saida !== 32'd12 || contador_instr !== 32'd3) begin
      nerr++; $display("FAIL stall_resume: pc=%h cnt=%0d required c/3", pc_saida, contador_instr); end
  endtask

  // Continues from the stall scenario: valido=1 with pc_saida=12.
  task automatic test_redirect();
    desvio_valido = 1; desvio_alvo = 32'h40;
    tick();
    desvio_valido = 0;
    nvec++; if (valido !== 1'b0 || contador_instr !== 32'd3) begin
      nerr++; $display("FAIL redirect_flush: v=%b cnt=%0d required 0/3", valido, contador_instr); end
    tick();
    nvec++; if (valido !== 1'b1 || pc_saida !== 32'h40 || instr_saida !== mem[16]) begin
      nerr++; $display("FAIL redirect_target: v=%b pc=%h instr=%h required 1/40/%h", valido, pc_saida, instr_saida, mem[16]); end
  endtask

  task automatic test_misaligned();
    logic [31:0] cnt0;
    logic [7:0]  a0;
    desvio_valido = 1; desvio_alvo = 32'h42;
    tick();
    cnt0 = contador_instr; a0 = endereco_instr;
    nvec++; if (erro_alinhamento !== 1'b1 || valido !== 1'b0 || a0 !== 8'd17) begin
      nerr++; $display("FAIL misalign_trap: erro=%b v=%b addr=%0d required 1/0/17", erro_alinhamento, valido, a0); end
    for (int i = 0; i < 10; i++) begin
      desvio_valido = 1'($urandom); desvio_alvo = $urandom & 32'h3FC; pronto = 1'($urandom);
      tick();
      nvec++; if (erro_alinhamento !== 1'b1 || valido !== 1'b0 || contador_instr !== cnt0 || endereco_instr !== a0) begin
        nerr++; $display("FAIL misalign_hold_%0d: erro=%b v=%b cnt=%0d addr=%0d", i, erro_alinhamento, valido, contador_instr, endereco_instr); end
    end
    do_reset();
    nvec++; if (erro_alinhamento !== 1'b0) begin nerr++; $display("FAIL misalign_clear: got %b required 0", erro_alinhamento); end
  endtask

  task automatic test_wrap();
    do_reset();
    nvec++; if (endereco2 !== 8'd255) begin nerr++; $display("FAIL wrap_reset_addr: got %0d required 255", endereco2); end
    tick(); tick();
    nvec++; if (endereco2 !== 8'd0 || pcs2 !== 32'h3FC || instr2 !== mem[255]) begin
      nerr++; $display("FAIL wrap_addr0: addr=%0d pc=%h instr=%h required 0/3fc/%h", endereco2, pcs2, instr2, mem[255]); end
    tick();
    nvec++; if (pcs2 !== 32'h400 || instr2 !== mem[0]) begin
      nerr++; $display("FAIL wrap_pc: pc=%h instr=%h required 400/%h", pcs2, instr2, mem[0]); end
  endtask

  task automatic test_midreset();
    do_reset();
    tick(); tick();
    pronto = 0;
    tick();
    rst_n = 0;
    tick();
    nvec++; if (valido !== 1'b0 || instr_saida !== 0 || pc_saida !== 0 || contador_instr !== 0 || erro_alinhamento !== 0 || endereco_instr !== 8'd0) begin
      nerr++; $display("FAIL midreset: v=%b instr=%h pc=%h cnt=%0d addr=%0d", valido, instr_saida, pc_saida, contador_instr, endereco_instr); end
    nvec++; if (endereco2 !== 8'd255 || valido2 !== 1'b0) begin
      nerr++; $display("FAIL midreset_dut2: addr=%0d v=%b required 255/0", endereco2, valido2); end
    rst_n = 1; pronto = 1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      pronto = ($urandom_range(0, 3) != 0);
      desvio_valido = ($urandom_range(0, 9) == 0);
      desvio_alvo = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
      nvec++; if (valido !== m_v || erro_alinhamento !== m_err || contador_instr !== m_cnt || endereco_instr !== m_pc[9:2]) begin
        nerr++; $display("FAIL rand_ctl_%0d: v=%b/%b erro=%b/%b cnt=%0d/%0d addr=%0d/%0d", c, valido, m_v, erro_alinhamento, m_err, contador_instr, m_cnt, endereco_instr, m_pc[9:2]); end
      if (m_v) begin
        nvec++; if (instr_saida !== m_instr || pc_saida !== m_pcs) begin
          nerr++; $display("FAIL rand_data_%0d: instr=%h/%h pc=%h/%h", c, instr_saida, m_instr, pc_saida, m_pcs); end
      end
    end
    rst_n = 1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h00002083; mem[1] = 32'h00102023; mem[2] = 32'h00108133;
    mem[3] = 32'h00110063; mem[4] = 32'h00000033;
    test_reset();
    test_sequence();
    test_stall();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
